uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one uart_tx instance between N_REQ byte producers, e.g. a register-dump engine, a command echo and a debug logger. Arbitration is round-robin. Each accepted byte is launched with a one-cycle start pulse, and the arbiter then waits for the transmitter's done tick before issuing another. Multi-byte messages are kept contiguous by a per-message lock, with a timeout so a stalled requester cannot hold the UART forever.

Parameters:
N_REQ, 4, number of requesters (2..8)
NB_DATA, 8, data width; must match uart_tx NB_DATA
NB_TOUT, 16, width of lock-timeout counter
LOCK_TIMEOUT, 16'd50000, consecutive idle clk cycles a locked requester may stall before its lock is dropped; must be ≥1

Ports:
clk  in  1  system clock
i_rst_n  in  1  reset; asynchronous, active-low
i_req_valid  in  N_REQ  per-requester byte available
i_req_data  in  N_REQ*NB_DATA  flattened bytes; requester k uses bits [k*NB_DATA +: NB_DATA]
i_req_last  in  N_REQ  byte is the last byte of its message
o_req_ack  out  N_REQ  one-cycle pulse: byte taken; requester advances
o_tx_start  out  1  one-cycle start pulse to uart_tx i_tx_start
o_tx_data  out  NB_DATA  byte to uart_tx i_data; held stable while busy
i_tx_done  in  1  uart_tx o_tx_done tick
o_busy  out  1  transmission in flight
o_grant_id  out  clog2(N_REQ)  requester owning the current or last byte
o_locked  out  1  mid-message lock active
o_lock_abort  out  1  one-cycle pulse: lock dropped by timeout

Behaviour:
- Reset (async, i_rst_n=0):
  - Outputs: all outputs 0, o_tx_data=0.
  - Internal state: state=IDLE, rr pointer=0, lock cleared, timeout counter=0.
  - In-flight byte: dropped with no ack. uart_tx may still finish it; the arbiter ignores i_tx_done outside BUSY.
- All outputs are registered.
- States:
  - IDLE:
    - Eligible set: if unlocked, all valid requesters; if locked, only the owner's valid.
    - If the eligible set is non-empty, the winner w is the first valid requester at or after rr pointer, cyclic.
    - Next edge: state=BUSY, o_tx_start=1, o_req_ack[w]=1, o_tx_data=byte w, o_grant_id=w, o_busy=1.
    - Lock update: if i_req_last[w]=0, lock is set to w; otherwise lock is cleared.
    - Latency: valid sampled in cycle T → start/ack visible in T+1.
  - BUSY:
    - o_tx_start and o_req_ack return to 0 after one cycle.
    - i_tx_done is sampled every BUSY cycle, including the first.
    - On done: state=IDLE and o_busy=0 at the next edge.
    - The next grant can therefore start one cycle after done; uart_tx is already idle by then.
    - All i_req_valid are ignored while BUSY.
- Round-robin:
  - Pointer is updated to (w+1) mod N_REQ on every grant.
  - While locked, the pointer does not affect selection.
- Lock timeout:
  - Counter increments each IDLE cycle in which lock is set and the owner's valid=0.
  - Counter clears on any grant.
  - When the counter reaches LOCK_TIMEOUT, at the next edge: lock is cleared, o_lock_abort pulses, counter=0.
  - Normal arbitration resumes in the following cycle.
- Simultaneous events:
  - Owner valid in the same cycle the timeout would fire: the grant wins and no abort occurs.
  - i_tx_done in IDLE: ignored.
- Data rule: i_req_data/i_req_last are sampled only in the winning cycle; requesters must hold them stable while valid=1 until ack.

Decomposition:
- Shared package uart_pkg:
  - state encodings IDLE/BUSY (one-hot, matching the UART FSM style)
  - NB_DATA default
  - clog2 helper constant for id width
- One natural sub-module: rr_picker.
  - Purely combinational.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, grant id, any-grant flag.
  - Reusable by future RX-side routing.

Test Plan:
- Single requester: req0 sends 0xA5 with last=1 → o_tx_start and o_req_ack[0] pulse 1 cycle after valid, o_tx_data=0xA5, o_busy falls the cycle after i_tx_done, o_locked stays 0.
- Round-robin: all 4 valid and last=1, pointer 0 → grant order 0,1,2,3,0; each start occurs exactly 1 cycle after the previous done.
- Lock: req2 sends 3 bytes (last=0,0,1) while req0 and req1 are continuously valid → the three req2 bytes go out back-to-back, then req3 is skipped (not valid) and req0 is granted.
- Timeout: LOCK_TIMEOUT=10; req1 sends last=0 then drops valid → o_lock_abort pulses once 10 idle cycles after the byte's done, o_locked→0, then pending req3 is granted.
- Mid-operation reset: assert i_rst_n=0 while BUSY → all outputs 0 asynchronously; a later i_tx_done while IDLE produces no activity; after release, first grant goes to req0.
- Spurious done and stability: pulse i_tx_done in IDLE → no state change; toggle req data while BUSY → o_tx_data unchanged.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART-side definitions: FSM encodings, default data width, id-width helper.
package uart_pkg;

    localparam int NB_DATA_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b01,
        BUSY = 2'b10
    } state_e;

    // Width of an index into n items; never less than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after the pointer, cyclic.
module rr_picker
    import uart_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = id_width(N)
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_ptr,
    output logic [N-1:0]   o_gnt,
    output logic [IDW-1:0] o_gnt_id,
    output logic           o_any
);

    int idx;

    always_comb begin
        o_gnt    = '0;
        o_gnt_id = '0;
        o_any    = 1'b0;
        idx      = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(i_ptr) + i) % N;
            if (!o_any && i_req[idx]) begin
                o_any      = 1'b1;
                o_gnt[idx] = 1'b1;
                o_gnt_id   = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx between N_REQ byte producers, with
// per-message lock and a stall timeout that drops the lock.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int                N_REQ        = 4,
    parameter int                NB_DATA      = NB_DATA_DEF,
    parameter int                NB_TOUT      = 16,
    parameter logic [NB_TOUT-1:0] LOCK_TIMEOUT = 16'd50000,
    localparam int               ID_W         = id_width(N_REQ)
) (
    input  logic                       clk,
    input  logic                       i_rst_n,
    input  logic [N_REQ-1:0]           i_req_valid,
    input  logic [N_REQ*NB_DATA-1:0]   i_req_data,
    input  logic [N_REQ-1:0]           i_req_last,
    output logic [N_REQ-1:0]           o_req_ack,
    output logic                       o_tx_start,
    output logic [NB_DATA-1:0]         o_tx_data,
    input  logic                       i_tx_done,
    output logic                       o_busy,
    output logic [ID_W-1:0]            o_grant_id,
    output logic                       o_locked,
    output logic                       o_lock_abort
);

    state_e               state_q, state_d;
    logic [ID_W-1:0]      rr_q, rr_d;
    logic                 lock_q, lock_d;
    logic [ID_W-1:0]      lock_id_q, lock_id_d;
    logic [NB_TOUT-1:0]   tout_q, tout_d;
    logic                 tx_start_q, tx_start_d;
    logic [N_REQ-1:0]     ack_q, ack_d;
    logic [NB_DATA-1:0]   tx_data_q, tx_data_d;
    logic [ID_W-1:0]      grant_id_q, grant_id_d;
    logic                 abort_q, abort_d;

    logic [N_REQ-1:0]     own_mask;
    logic [N_REQ-1:0]     eligible;
    logic [N_REQ-1:0]     gnt;
    logic [ID_W-1:0]      gnt_id;
    logic                 gnt_any;
    logic                 grant;

    // While locked only the owner may compete, so the pointer is irrelevant.
    always_comb begin
        own_mask           = '0;
        own_mask[lock_id_q] = 1'b1;
        eligible           = lock_q ? (i_req_valid & own_mask) : i_req_valid;
    end

    rr_picker #(
        .N   (N_REQ),
        .IDW (ID_W)
    ) u_rr_picker (
        .i_req    (eligible),
        .i_ptr    (rr_q),
        .o_gnt    (gnt),
        .o_gnt_id (gnt_id),
        .o_any    (gnt_any)
    );

    assign grant = (state_q == IDLE) && gnt_any;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_id_q  <= '0;
            tout_q     <= '0;
            tx_start_q <= 1'b0;
            ack_q      <= '0;
            tx_data_q  <= '0;
            grant_id_q <= '0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_id_q  <= lock_id_d;
            tout_q     <= tout_d;
            tx_start_q <= tx_start_d;
            ack_q      <= ack_d;
            tx_data_q  <= tx_data_d;
            grant_id_q <= grant_id_d;
            abort_q    <= abort_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = BUSY;
            BUSY:    if (i_tx_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rr_d       = rr_q;
        lock_d     = lock_q;
        lock_id_d  = lock_id_q;
        tout_d     = tout_q;
        tx_start_d = 1'b0;
        ack_d      = '0;
        tx_data_d  = tx_data_q;
        grant_id_d = grant_id_q;
        abort_d    = 1'b0;
        if (grant) begin
            tx_start_d = 1'b1;
            ack_d      = gnt;
            tx_data_d  = i_req_data[int'(gnt_id)*NB_DATA +: NB_DATA];
            grant_id_d = gnt_id;
            rr_d       = (gnt_id == ID_W'(N_REQ-1)) ? '0 : gnt_id + ID_W'(1);
            lock_d     = ~i_req_last[gnt_id];
            lock_id_d  = gnt_id;
            tout_d     = '0;
        end else if (state_q == IDLE && lock_q) begin
            // Owner stalled: count, and once the limit is held drop the lock.
            if (tout_q == LOCK_TIMEOUT) begin
                lock_d  = 1'b0;
                abort_d = 1'b1;
                tout_d  = '0;
            end else begin
                tout_d = tout_q + NB_TOUT'(1);
            end
        end
    end

    assign o_req_ack    = ack_q;
    assign o_tx_start   = tx_start_q;
    assign o_tx_data    = tx_data_q;
    assign o_busy       = state_q[1];
    assign o_grant_id   = grant_id_q;
    assign o_locked     = lock_q;
    assign o_lock_abort = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with 4 requesters and a short lock timeout.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int NB = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [N*NB-1:0] req_data = '0;
    logic [N-1:0]  req_last = '0;
    logic [N-1:0]  ack;
    logic          tx_start;
    logic [NB-1:0] tx_data;
    logic          tx_done = 1'b0;
    logic          busy;
    logic [1:0]    grant_id;
    logic          locked;
    logic          lock_abort;

    int errors = 0;
    int checks = 0;

    uart_tx_arbiter #(
        .N_REQ        (N),
        .NB_DATA      (NB),
        .NB_TOUT      (16),
        .LOCK_TIMEOUT (16'd10)
    ) dut (
        .clk          (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .i_req_data   (req_data),
        .i_req_last   (req_last),
        .o_req_ack    (ack),
        .o_tx_start   (tx_start),
        .o_tx_data    (tx_data),
        .i_tx_done    (tx_done),
        .o_busy       (busy),
        .o_grant_id   (grant_id),
        .o_locked     (locked),
        .o_lock_abort (lock_abort)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        req_last  = '0;
        tx_done   = 1'b0;
        rst_n     = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic set_req(input int k, input logic [7:0] d, input logic last);
        req_valid[k]       = 1'b1;
        req_data[k*NB +: NB] = d;
        req_last[k]        = last;
    endtask

    // Pulse done so it is sampled at the next edge.
    task automatic done_pulse();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({ack, tx_start, tx_data, busy, grant_id, locked, lock_abort} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ack=%b start=%b data=%h busy=%b id=%0d lock=%b abort=%b, want all 0",
                     ack, tx_start, tx_data, busy, grant_id, locked, lock_abort);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        set_req(0, 8'hA5, 1'b1);
        tick();
        checks++;
        if ({tx_start, ack, tx_data, busy, grant_id, locked} !== {1'b1, 4'b0001, 8'hA5, 1'b1, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL single_grant: got start=%b ack=%b data=%h busy=%b id=%0d lock=%b, want 1 0001 a5 1 0 0",
                     tx_start, ack, tx_data, busy, grant_id, locked);
        end
        req_valid[0] = 1'b0;
        tick();
        checks++;
        if ({tx_start, ack, busy} !== {1'b0, 4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL single_pulse_width: got start=%b ack=%b busy=%b, want 0 0000 1", tx_start, ack, busy);
        end
        done_pulse();
        checks++;
        if ({busy, locked, tx_start} !== 3'b000) begin
            errors++;
            $display("FAIL single_done: got busy=%b lock=%b start=%b, want 0 0 0", busy, locked, tx_start);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        for (int k = 0; k < N; k++) set_req(k, 8'h10 + 8'(k), 1'b1);
        tick();
        for (int g = 0; g < 5; g++) begin
            checks++;
            if (tx_start !== 1'b1 || grant_id !== exp_id[g] || tx_data !== 8'h10 + 8'(exp_id[g])) begin
                errors++;
                $display("FAIL rr_grant%0d: got start=%b id=%0d data=%h, want start=1 id=%0d data=%h",
                         g, tx_start, grant_id, tx_data, exp_id[g], 8'h10 + 8'(exp_id[g]));
            end
            done_pulse();
            tick();
        end
        req_valid = '0;
        tick();
        done_pulse();
    endtask

    task automatic test_lock();
        logic [7:0] bytes [3] = '{8'hB1, 8'hB2, 8'hB3};
        logic       lasts [3] = '{1'b0, 1'b0, 1'b1};
        do_reset();
        set_req(2, bytes[0], lasts[0]);
        tick();
        set_req(0, 8'h0A, 1'b1);
        set_req(1, 8'h1A, 1'b1);
        for (int b = 0; b < 3; b++) begin
            checks++;
            if (tx_start !== 1'b1 || grant_id !== 2'd2 || tx_data !== bytes[b] || locked !== !lasts[b]) begin
                errors++;
                $display("FAIL lock_byte%0d: got start=%b id=%0d data=%h lock=%b, want 1 2 %h %b",
                         b, tx_start, grant_id, tx_data, locked, bytes[b], !lasts[b]);
            end
            if (b < 2) set_req(2, bytes[b+1], lasts[b+1]);
            else req_valid[2] = 1'b0;
            done_pulse();
            tick();
        end
        checks++;
        if (tx_start !== 1'b1 || grant_id !== 2'd0 || tx_data !== 8'h0A) begin
            errors++;
            $display("FAIL lock_release: got start=%b id=%0d data=%h, want 1 0 0a", tx_start, grant_id, tx_data);
        end
        req_valid = '0;
        tick();
        done_pulse();
    endtask

    task automatic test_timeout();
        int bad;
        do_reset();
        set_req(1, 8'h11, 1'b0);
        set_req(3, 8'h33, 1'b1);
        tick();
        checks++;
        if (tx_start !== 1'b1 || grant_id !== 2'd1 || locked !== 1'b1) begin
            errors++;
            $display("FAIL tout_first: got start=%b id=%0d lock=%b, want 1 1 1", tx_start, grant_id, locked);
        end
        req_valid[1] = 1'b0;
        done_pulse();
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (lock_abort !== 1'b0 || locked !== 1'b1 || tx_start !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL tout_hold: %0d early cycles with abort/unlock/start, want 0", bad);
        end
        tick();
        checks++;
        if (lock_abort !== 1'b1 || locked !== 1'b0 || tx_start !== 1'b0) begin
            errors++;
            $display("FAIL tout_abort: got abort=%b lock=%b start=%b, want 1 0 0", lock_abort, locked, tx_start);
        end
        tick();
        checks++;
        if (lock_abort !== 1'b0 || tx_start !== 1'b1 || grant_id !== 2'd3 || tx_data !== 8'h33) begin
            errors++;
            $display("FAIL tout_resume: got abort=%b start=%b id=%0d data=%h, want 0 1 3 33",
                     lock_abort, tx_start, grant_id, tx_data);
        end
        req_valid = '0;
        done_pulse();

        // Owner returns exactly when the timeout would fire: grant wins.
        do_reset();
        set_req(1, 8'h21, 1'b0);
        tick();
        req_valid[1] = 1'b0;
        done_pulse();
        for (int c = 0; c < 10; c++) tick();
        set_req(1, 8'h22, 1'b1);
        tick();
        checks++;
        if (tx_start !== 1'b1 || lock_abort !== 1'b0 || grant_id !== 2'd1 || tx_data !== 8'h22) begin
            errors++;
            $display("FAIL tout_race: got start=%b abort=%b id=%0d data=%h, want 1 0 1 22",
                     tx_start, lock_abort, grant_id, tx_data);
        end
        req_valid = '0;
        done_pulse();
    endtask

    task automatic test_mid_reset();
        int bad;
        do_reset();
        set_req(1, 8'h5A, 1'b1);
        tick();
        req_valid = '0;
        tick();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({ack, tx_start, tx_data, busy, grant_id, locked, lock_abort} !== '0) begin
            errors++;
            $display("FAIL midrst_async: got busy=%b data=%h id=%0d, want all 0", busy, tx_data, grant_id);
        end
        tick();
        rst_n = 1'b1;
        tick();
        done_pulse();
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            if (busy !== 1'b0 || tx_start !== 1'b0 || ack !== 4'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midrst_late_done: %0d cycles with activity, want 0", bad);
        end
        set_req(0, 8'h01, 1'b1);
        set_req(2, 8'h02, 1'b1);
        tick();
        checks++;
        if (tx_start !== 1'b1 || grant_id !== 2'd0 || ack !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_ptr: got start=%b id=%0d ack=%b, want 1 0 0001", tx_start, grant_id, ack);
        end
        req_valid = '0;
        done_pulse();
    endtask

    task automatic test_stability();
        int bad;
        do_reset();
        done_pulse();
        checks++;
        if (busy !== 1'b0 || tx_start !== 1'b0 || ack !== 4'b0) begin
            errors++;
            $display("FAIL spurious_done: got busy=%b start=%b ack=%b, want 0 0 0000", busy, tx_start, ack);
        end
        set_req(3, 8'h3C, 1'b1);
        tick();
        checks++;
        if (tx_start !== 1'b1 || grant_id !== 2'd3 || tx_data !== 8'h3C) begin
            errors++;
            $display("FAIL stab_grant: got start=%b id=%0d data=%h, want 1 3 3c", tx_start, grant_id, tx_data);
        end
        set_req(0, 8'hE0, 1'b1);
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            req_data[3*NB +: NB] = 8'hF0 + 8'(c);
            tick();
            if (tx_data !== 8'h3C || tx_start !== 1'b0 || ack !== 4'b0 || busy !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stab_hold: %0d busy cycles with changed data or new grant, want 0", bad);
        end
        req_valid = '0;
        done_pulse();
        checks++;
        if (busy !== 1'b0 || tx_data !== 8'h3C) begin
            errors++;
            $display("FAIL stab_done: got busy=%b data=%h, want 0 3c", busy, tx_data);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_timeout();
        test_mid_reset();
        test_stability();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
